// File: rtl/vscpu_hs_if.sv
// Memory handshake bundle between the CPU (master) and a word-addressed memory (slave).
// One request is outstanding at a time; mem_ack may come in the same cycle as mem_req.
interface vscpu_hs_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/vscpu_hs.sv
// Very small memory-to-memory CPU on a req/ack memory handshake, one access per state.
// Define VSCPU_MUL_EN to execute MUL/MULi; without it those opcodes halt the CPU.
module vscpu_hs #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    vscpu_hs_if.master bus,
    output logic       halted
);

    if (DATA_W < 2*ADDR_W + 4) begin : g_param_check
        $error("vscpu_hs: DATA_W must be at least 2*ADDR_W+4");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_RDA,
        S_RDB,
        S_RDI,
        S_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_CP   = 3'b100;
    localparam logic [2:0] OP_CPI  = 3'b101;
    localparam logic [2:0] OP_BZJ  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] iw_q, iw_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              halted_q, halted_d;

    // First access after the fetch, chosen from the freshly fetched opcode.
    function automatic state_t after_fetch(input logic [3:0] op);
        state_t nxt;
        case (op[3:1])
            OP_CP:   nxt = op[0] ? S_WR : S_RDB;
            OP_CPI:  nxt = op[0] ? S_RDA : S_RDB;
`ifndef VSCPU_MUL_EN
            OP_MUL:  nxt = S_HALT;
`endif
            default: nxt = S_RDA;
        endcase
        return nxt;
    endfunction

    // Fields of the instruction currently held in iw_q
    logic [2:0]        op3_q;
    logic              imm_q;
    logic [ADDR_W-1:0] b_fld_q;

    assign op3_q   = iw_q[DATA_W-1 -: 3];
    assign imm_q   = iw_q[DATA_W-4];
    assign b_fld_q = iw_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iw_d    = iw_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    iw_d    = bus.mem_rdata;
                    state_d = after_fetch(bus.mem_rdata[DATA_W-1 -: 4]);
                end
            end
            S_RDA: begin
                if (bus.mem_ack) begin
                    a_d = bus.mem_rdata;
                    if (op3_q == OP_BZJ && imm_q) begin
                        pc_d    = bus.mem_rdata[ADDR_W-1:0] + b_fld_q;
                        state_d = S_FETCH;
                    end else if (imm_q && op3_q != OP_CPI) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RDB;
                    end
                end
            end
            S_RDB: begin
                if (bus.mem_ack) begin
                    b_d = bus.mem_rdata;
                    if (op3_q == OP_BZJ) begin
                        pc_d    = (bus.mem_rdata == '0) ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
                        state_d = S_FETCH;
                    end else if (op3_q == OP_CPI && !imm_q) begin
                        state_d = S_RDI;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RDI: begin
                if (bus.mem_ack) begin
                    b_d     = bus.mem_rdata;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.mem_ack) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Fields of the instruction that will be current next cycle
    logic [2:0]        op3_d;
    logic              imm_d;
    logic [ADDR_W-1:0] a_fld_d;
    logic [ADDR_W-1:0] b_fld_d;
    logic [DATA_W-1:0] y_val;
    logic [DATA_W-1:0] result;

    assign op3_d   = iw_d[DATA_W-1 -: 3];
    assign imm_d   = iw_d[DATA_W-4];
    assign a_fld_d = iw_d[2*ADDR_W-1:ADDR_W];
    assign b_fld_d = iw_d[ADDR_W-1:0];

    always_comb begin
        y_val  = imm_d ? {{(DATA_W-ADDR_W){1'b0}}, b_fld_d} : b_d;
        result = '0;
        case (op3_d)
            OP_ADD:  result = a_d + y_val;
            OP_NAND: result = ~(a_d & y_val);
            OP_SRL:  result = (y_val < DW_VAL) ? (a_d >> y_val) : (a_d << (y_val - DW_VAL));
            OP_LT:   result = {{(DATA_W-1){1'b0}}, (a_d < y_val)};
            OP_CP:   result = y_val;
            // CPI leaves the indirectly read word in b; CPIi leaves *B there
            OP_CPI:  result = b_d;
`ifdef VSCPU_MUL_EN
            OP_MUL:  result = a_d * y_val;
`endif
            default: result = '0;
        endcase
    end

    // Bus outputs are registered from the next-state values, so they hold while ack is low.
    always_comb begin
        req_d    = (state_d != S_HALT);
        we_d     = (state_d == S_WR);
        halted_d = (state_d == S_HALT);
        wdata_d  = (state_d == S_WR) ? result : '0;
        addr_d   = '0;
        case (state_d)
            S_FETCH: addr_d = pc_d;
            S_RDA:   addr_d = a_fld_d;
            S_RDB:   addr_d = b_fld_d;
            S_RDI:   addr_d = b_d[ADDR_W-1:0];
            S_WR:    addr_d = (op3_d == OP_CPI && imm_d) ? a_d[ADDR_W-1:0] : a_fld_d;
            default: addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            iw_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            iw_q     <= iw_d;
            a_q      <= a_d;
            b_q      <= b_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    // Outputs are forced quiet for the whole of any cycle in which rst is high.
    assign bus.mem_req   = req_q & ~rst;
    assign bus.mem_we    = we_q & ~rst;
    assign bus.mem_addr  = rst ? '0 : addr_q;
    assign bus.mem_wdata = rst ? '0 : wdata_q;
    assign halted        = halted_q & ~rst;

endmodule

// File: tb/tb_vscpu_hs.sv
// Self-checking bench for vscpu_hs: table of single-instruction vectors plus hand-written
// sequences for wait states, pc wrap, reset during a write, self-modifying code and MUL.
module tb_vscpu_hs;
    localparam int AW = 14;
    localparam int DW = 32;

    localparam logic [3:0] ADD   = 4'b0000;
    localparam logic [3:0] ADDI  = 4'b0001;
    localparam logic [3:0] NAND  = 4'b0010;
    localparam logic [3:0] NANDI = 4'b0011;
    localparam logic [3:0] SRL   = 4'b0100;
    localparam logic [3:0] SRLI  = 4'b0101;
    localparam logic [3:0] LT    = 4'b0110;
    localparam logic [3:0] LTI   = 4'b0111;
    localparam logic [3:0] CP    = 4'b1000;
    localparam logic [3:0] CPIM  = 4'b1001;
    localparam logic [3:0] CPI   = 4'b1010;
    localparam logic [3:0] CPII  = 4'b1011;
    localparam logic [3:0] BZJ   = 4'b1100;
    localparam logic [3:0] BZJI  = 4'b1101;
    localparam logic [3:0] MUL   = 4'b1110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    always #5 clk = ~clk;

    vscpu_hs_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vscpu_hs #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .halted (halted)
    );

    // Memory model with programmable wait states and a bench load port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int unsigned   wait_cnt = 0;
    int unsigned   ack_delay = 0;
    logic          ack_force = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    assign bus.mem_ack   = (bus.mem_req && (wait_cnt >= ack_delay)) || ack_force;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (bus.mem_req && bus.mem_ack && bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.mem_req || bus.mem_ack)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc(input logic [3:0] op, input logic [AW-1:0] a,
                                          input logic [AW-1:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [63:0] fetch_of(input logic [AW-1:0] pc);
        return {48'd0, 1'b1, 1'b0, pc};
    endfunction

    function automatic logic [63:0] bus_now();
        return {48'd0, bus.mem_req, bus.mem_we, bus.mem_addr};
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
        end
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] vc;
        int            cycles;
        int            chk;
        logic [DW-1:0] exp_val;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int            n;
        bit            done;
        bit            stable_ok;
        logic          p_wait;
        logic [63:0]   p_bus;
        logic [DW-1:0] p_wd;

        // instr at 0, mem[10]=va, mem[11]=vb, mem[12]=vc
        vecs[0]  = '{enc(ADD,   14'd10, 14'd11),  32'd5,         32'd7,         32'd0,         4, 10, 32'd12,        14'd1};
        vecs[1]  = '{enc(ADDI,  14'd10, 14'd100), 32'hFFFF_FFFF, 32'd0,         32'd0,         3, 10, 32'd99,        14'd1};
        vecs[2]  = '{enc(NAND,  14'd10, 14'd11),  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         4, 10, 32'h0FFF_0FFF, 14'd1};
        vecs[3]  = '{enc(NANDI, 14'd10, 14'h0FF), 32'h0000_0F0F, 32'd0,         32'd0,         3, 10, 32'hFFFF_FFF0, 14'd1};
        vecs[4]  = '{enc(SRLI,  14'd10, 14'd33),  32'h8000_0000, 32'd0,         32'd0,         3, 10, 32'h0000_0000, 14'd1};
        vecs[5]  = '{enc(SRLI,  14'd10, 14'd4),   32'h8000_0000, 32'd0,         32'd0,         3, 10, 32'h0800_0000, 14'd1};
        vecs[6]  = '{enc(SRL,   14'd10, 14'd11),  32'h1234_5678, 32'd8,         32'd0,         4, 10, 32'h0012_3456, 14'd1};
        vecs[7]  = '{enc(SRL,   14'd10, 14'd11),  32'h0000_0001, 32'd32,        32'd0,         4, 10, 32'h0000_0001, 14'd1};
        vecs[8]  = '{enc(LT,    14'd10, 14'd11),  32'd3,         32'hFFFF_FFFF, 32'd0,         4, 10, 32'd1,         14'd1};
        vecs[9]  = '{enc(LTI,   14'd10, 14'd5),   32'd5,         32'd0,         32'd0,         3, 10, 32'd0,         14'd1};
        vecs[10] = '{enc(CP,    14'd10, 14'd11),  32'd1,         32'hDEAD_BEEF, 32'd0,         3, 10, 32'hDEAD_BEEF, 14'd1};
        vecs[11] = '{enc(CPIM,  14'd10, 14'h3FFF),32'h11,        32'd0,         32'd0,         2, 10, 32'h0000_3FFF, 14'd1};
        vecs[12] = '{enc(CPI,   14'd10, 14'd11),  32'd0,         32'd12,        32'hCAFE_F00D, 4, 10, 32'hCAFE_F00D, 14'd1};
        vecs[13] = '{enc(CPII,  14'd10, 14'd11),  32'd12,        32'h55AA,      32'd0,         4, 12, 32'h0000_55AA, 14'd1};
        vecs[14] = '{enc(BZJ,   14'd10, 14'd11),  32'd20,        32'd0,         32'd0,         3, 10, 32'd20,        14'd20};
        vecs[15] = '{enc(BZJ,   14'd10, 14'd11),  32'd20,        32'd1,         32'd0,         3, 10, 32'd20,        14'd1};
        vecs[16] = '{enc(BZJI,  14'd10, 14'd5),   32'd30,        32'd0,         32'd0,         2, 10, 32'd30,        14'd35};

        // Reset state
        step(2);
        check("rst_req",    {63'd0, bus.mem_req},  64'd0);
        check("rst_we",     {63'd0, bus.mem_we},   64'd0);
        check("rst_addr",   {50'd0, bus.mem_addr}, 64'd0);
        check("rst_wdata",  {32'd0, bus.mem_wdata},64'd0);
        check("rst_halted", {63'd0, halted},       64'd0);

        // Table of single instructions with zero-wait memory
        for (int i = 0; i < 17; i++) begin
            rst = 1'b1;
            load(14'd0,  vecs[i].instr);
            load(14'd10, vecs[i].va);
            load(14'd11, vecs[i].vb);
            load(14'd12, vecs[i].vc);
            rst = 1'b0;
            #1;
            check($sformatf("vec%0d_first_fetch", i), bus_now(), fetch_of(14'd0));
            step(vecs[i].cycles);
            check($sformatf("vec%0d_result", i), {32'd0, mem[vecs[i].chk]}, {32'd0, vecs[i].exp_val});
            check($sformatf("vec%0d_next_fetch", i), bus_now(), fetch_of(vecs[i].exp_pc));
            $display("vec %0d instr=%08h mem[%0d]=%08h next_addr=%0d", i, vecs[i].instr,
                     vecs[i].chk, mem[vecs[i].chk], bus.mem_addr);
        end

        // ADD with three wait states on every access
        rst = 1'b1;
        ack_delay = 3;
        load(14'd0,  enc(ADD, 14'd10, 14'd11));
        load(14'd10, 32'd5);
        load(14'd11, 32'd7);
        rst = 1'b0;
        #1;
        p_wait    = bus.mem_req && !bus.mem_ack;
        p_bus     = bus_now();
        p_wd      = bus.mem_wdata;
        n         = 0;
        done      = 1'b0;
        stable_ok = 1'b1;
        while (!done && n < 64) begin
            step(1);
            n++;
            if (p_wait && (bus_now() !== p_bus || bus.mem_wdata !== p_wd))
                stable_ok = 1'b0;
            p_wait = bus.mem_req && !bus.mem_ack;
            p_bus  = bus_now();
            p_wd   = bus.mem_wdata;
            if (bus.mem_req && !bus.mem_we && bus.mem_addr == 14'd1)
                done = 1'b1;
        end
        check("dly_cycles", 64'(n), 64'd16);
        check("dly_stable", {63'd0, stable_ok}, 64'd1);
        check("dly_result", {32'd0, mem[10]}, 64'd12);
        $display("delayed ADD cycles=%0d mem[10]=%0d", n, mem[10]);

        // BZJ at the last address falls through to address 0
        rst = 1'b1;
        ack_delay = 0;
        load(14'd0,     enc(BZJI, 14'd10, 14'h3FFF));
        load(14'd10,    32'd0);
        load(14'h3FFF,  enc(BZJ, 14'd11, 14'd12));
        load(14'd11,    32'd20);
        load(14'd12,    32'd5);
        rst = 1'b0;
        step(2);
        check("wrap_jump_top", bus_now(), fetch_of(14'h3FFF));
        step(3);
        check("wrap_to_zero", bus_now(), fetch_of(14'd0));
        $display("BZJ wrap next_addr=%0d", bus.mem_addr);

        // Reset while a write waits for its ack
        rst = 1'b1;
        ack_delay = 3;
        load(14'd0,  enc(CPIM, 14'd10, 14'h123));
        load(14'd10, 32'h777);
        rst = 1'b0;
        step(5);
        check("wr_pending", bus_now(), {48'd0, 1'b1, 1'b1, 14'd10});
        rst = 1'b1;
        ack_force = 1'b1;
        #1;
        check("rstwr_req", {63'd0, bus.mem_req}, 64'd0);
        check("rstwr_we",  {63'd0, bus.mem_we},  64'd0);
        step(2);
        ack_force = 1'b0;
        rst = 1'b0;
        #1;
        check("rstwr_target", {32'd0, mem[10]}, 64'h777);
        check("rstwr_fetch0", bus_now(), fetch_of(14'd0));
        $display("reset during WR mem[10]=%08h next_addr=%0d", mem[10], bus.mem_addr);

        // Self-modifying code: CP overwrites the instruction at address 1
        rst = 1'b1;
        ack_delay = 0;
        load(14'd0,  enc(CP,   14'd1,  14'd11));
        load(14'd1,  enc(CPIM, 14'd10, 14'h99));
        load(14'd10, 32'd0);
        load(14'd11, enc(CPIM, 14'd10, 14'h55));
        rst = 1'b0;
        step(5);
        check("smc_result", {32'd0, mem[10]}, 64'h55);
        $display("self-modify mem[10]=%08h", mem[10]);

        // MUL: executes when enabled, otherwise halts
        rst = 1'b1;
        load(14'd0,  enc(MUL, 14'd10, 14'd11));
        load(14'd10, 32'd3);
        load(14'd11, 32'd5);
        rst = 1'b0;
`ifdef VSCPU_MUL_EN
        step(4);
        check("mul_result", {32'd0, mem[10]}, 64'd15);
        check("mul_fetch",  bus_now(), fetch_of(14'd1));
`else
        step(1);
        check("mul_halted", {63'd0, halted},      64'd1);
        check("mul_noreq",  {63'd0, bus.mem_req}, 64'd0);
        step(5);
        check("mul_still_halted", {63'd0, halted},      64'd1);
        check("mul_still_noreq",  {63'd0, bus.mem_req}, 64'd0);
        check("mul_no_write",     {32'd0, mem[10]},     64'd3);
        rst = 1'b1;
        #1;
        check("mul_rst_halted", {63'd0, halted}, 64'd0);
        step(1);
        rst = 1'b0;
        #1;
        check("mul_rst_fetch0", bus_now(), fetch_of(14'd0));
`endif
        $display("MUL mem[10]=%0d halted=%0d", mem[10], halted);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
